// File: rtl/pq_mc.sv
// ---------------------------------------------------------------------------
// pq_mc : multi-channel sorted priority queue with ID allocation and eviction
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pq_mc #(
  parameter  int DEPTH     = 16,
  parameter  int NUM_CH    = 4,
  parameter  int KW        = 8,
  parameter  int DW        = 16,
  parameter  int MIN_FIRST = 1,
  parameter  int EVICT     = 1,
  localparam int IDW       = $clog2(DEPTH),
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNTW      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [CW-1:0]     push_ch_i,
  input  logic [KW-1:0]     push_key_i,
  input  logic [DW-1:0]     push_data_i,
  output logic              push_rdy_o,
  output logic [IDW-1:0]    push_id_o,
  input  logic              pop_i,
  input  logic [CW-1:0]     pop_ch_i,
  output logic              pop_rdy_o,
  output logic [KW-1:0]     pop_key_o,
  output logic [DW-1:0]     pop_data_o,
  output logic [IDW-1:0]    pop_id_o,
  input  logic              drop_i,
  input  logic [IDW-1:0]    drop_id_i,
  output logic              drop_rdy_o,
  output logic              drop_hit_o,
  output logic [NUM_CH-1:0] ch_nonempty_o,
  output logic [CNTW-1:0]   cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic [KW-1:0]     ovf_key_o,
  output logic [DW-1:0]     ovf_data_o,
  output logic [IDW-1:0]    ovf_id_o
);

  localparam logic [CNTW-1:0] C_FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] C_ONE  = CNTW'(1);

  function automatic logic f_better(input logic [KW-1:0] a, input logic [KW-1:0] b);
    return (MIN_FIRST != 0) ? (a < b) : (a > b);
  endfunction

  logic [CW-1:0]   ch_q   [DEPTH];
  logic [CW-1:0]   ch_d   [DEPTH];
  logic [KW-1:0]   key_q  [DEPTH];
  logic [KW-1:0]   key_d  [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [DW-1:0]   data_d [DEPTH];
  logic [IDW-1:0]  id_q   [DEPTH];
  logic [IDW-1:0]  id_d   [DEPTH];
  logic [DEPTH-1:0] used_q, used_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [KW-1:0]   ovf_key_q, ovf_key_d;
  logic [DW-1:0]   ovf_data_q, ovf_data_d;
  logic [IDW-1:0]  ovf_id_q, ovf_id_d;

  logic [DEPTH-1:0]   w_valid;
  logic [2**CW-1:0]   w_ne_all;
  logic               w_pop_hit;
  logic [IDW-1:0]     w_pop_idx;
  logic [IDW-1:0]     w_drop_idx;
  logic [IDW-1:0]     w_ins_pos;
  logic [IDW-1:0]     w_free_id;
  logic               w_full;
  logic               w_evict_ok;
  logic               w_rm;
  logic [IDW-1:0]     w_rm_idx;

  // Valid entries are packed at the low end, so occupancy follows from the count.
  always_comb begin
    w_valid    = '0;
    w_ne_all   = '0;
    w_pop_hit  = 1'b0;
    w_pop_idx  = '0;
    drop_hit_o = 1'b0;
    w_drop_idx = '0;
    w_ins_pos  = cnt_q[IDW-1:0];
    w_free_id  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_valid[i] = (i < int'(cnt_q));
      if (w_valid[i]) begin
        w_ne_all[ch_q[i]] = 1'b1;
        if (ch_q[i] == pop_ch_i) begin
          w_pop_hit = 1'b1;
          w_pop_idx = IDW'(i);
        end
        if (id_q[i] == drop_id_i) begin
          drop_hit_o = 1'b1;
          w_drop_idx = IDW'(i);
        end
        if (f_better(push_key_i, key_q[i])) w_ins_pos = IDW'(i);
      end
      if (!used_q[i]) w_free_id = IDW'(i);
    end
  end

  assign w_full        = (cnt_q == C_FULL);
  assign w_evict_ok    = (EVICT != 0) && f_better(push_key_i, key_q[DEPTH-1]);
  assign push_rdy_o    = ~drop_i & ~pop_i & (~w_full | w_evict_ok);
  assign push_id_o     = (w_full && (EVICT != 0)) ? id_q[DEPTH-1] : w_free_id;
  assign pop_rdy_o     = ~drop_i & w_ne_all[pop_ch_i];
  assign pop_key_o     = w_pop_hit ? key_q[w_pop_idx]  : '0;
  assign pop_data_o    = w_pop_hit ? data_q[w_pop_idx] : '0;
  assign pop_id_o      = w_pop_hit ? id_q[w_pop_idx]   : '0;
  assign drop_rdy_o    = 1'b1;
  assign ch_nonempty_o = w_ne_all[NUM_CH-1:0];
  assign cnt_o         = cnt_q;
  assign full_o        = w_full;
  assign empty_o       = (cnt_q == '0);
  assign ovf_o         = ovf_q;
  assign ovf_key_o     = ovf_key_q;
  assign ovf_data_o    = ovf_data_q;
  assign ovf_id_o      = ovf_id_q;

  always_comb begin
    ch_d       = ch_q;
    key_d      = key_q;
    data_d     = data_q;
    id_d       = id_q;
    used_d     = used_q;
    cnt_d      = cnt_q;
    ovf_d      = 1'b0;
    ovf_key_d  = ovf_key_q;
    ovf_data_d = ovf_data_q;
    ovf_id_d   = ovf_id_q;
    w_rm       = 1'b0;
    w_rm_idx   = '0;
    if (drop_i) begin
      w_rm     = drop_hit_o;
      w_rm_idx = w_drop_idx;
    end else if (pop_i && pop_rdy_o) begin
      w_rm     = 1'b1;
      w_rm_idx = w_pop_idx;
    end
    if (w_rm) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(w_rm_idx)) begin
          ch_d[i]   = ch_q[i+1];
          key_d[i]  = key_q[i+1];
          data_d[i] = data_q[i+1];
          id_d[i]   = id_q[i+1];
        end
      end
      used_d[id_q[w_rm_idx]] = 1'b0;
      cnt_d = cnt_q - C_ONE;
    end else if (push_i && push_rdy_o) begin
      // When full the tail entry falls off the end of the shift; its ID is reused.
      if (w_full) begin
        ovf_d      = 1'b1;
        ovf_key_d  = key_q[DEPTH-1];
        ovf_data_d = data_q[DEPTH-1];
        ovf_id_d   = id_q[DEPTH-1];
      end else begin
        used_d[w_free_id] = 1'b1;
        cnt_d = cnt_q + C_ONE;
      end
      for (int i = DEPTH - 1; i > 0; i--) begin
        if (i > int'(w_ins_pos)) begin
          ch_d[i]   = ch_q[i-1];
          key_d[i]  = key_q[i-1];
          data_d[i] = data_q[i-1];
          id_d[i]   = id_q[i-1];
        end
      end
      ch_d[w_ins_pos]   = push_ch_i;
      key_d[w_ins_pos]  = push_key_i;
      data_d[w_ins_pos] = push_data_i;
      id_d[w_ins_pos]   = push_id_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ch_q[i]   <= '0;
        key_q[i]  <= '0;
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      used_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_key_q  <= '0;
      ovf_data_q <= '0;
      ovf_id_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ch_q[i]   <= ch_d[i];
        key_q[i]  <= key_d[i];
        data_q[i] <= data_d[i];
        id_q[i]   <= id_d[i];
      end
      used_q     <= used_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ovf_key_q  <= ovf_key_d;
      ovf_data_q <= ovf_data_d;
      ovf_id_q   <= ovf_id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pq_mc.sv
// ---------------------------------------------------------------------------
// tb_pq_mc : scoreboard bench for pq_mc against an unordered-set reference
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pq_mc;

  localparam int DEPTH     = 4;
  localparam int NUM_CH    = 4;
  localparam int MIN_FIRST = 1;
  localparam int EVICT     = 1;

  logic        clk_i, rst_i;
  logic        push_i, pop_i, drop_i;
  logic [1:0]  push_ch_i, pop_ch_i, drop_id_i;
  logic [7:0]  push_key_i;
  logic [15:0] push_data_i;
  logic        push_rdy_o, pop_rdy_o, drop_rdy_o, drop_hit_o;
  logic [1:0]  push_id_o, pop_id_o, ovf_id_o;
  logic [7:0]  pop_key_o, ovf_key_o;
  logic [15:0] pop_data_o, ovf_data_o;
  logic [3:0]  ch_nonempty_o;
  logic [2:0]  cnt_o;
  logic        full_o, empty_o, ovf_o;

  pq_mc #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .KW(8), .DW(16),
          .MIN_FIRST(MIN_FIRST), .EVICT(EVICT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(push_i), .push_ch_i(push_ch_i), .push_key_i(push_key_i),
    .push_data_i(push_data_i), .push_rdy_o(push_rdy_o), .push_id_o(push_id_o),
    .pop_i(pop_i), .pop_ch_i(pop_ch_i), .pop_rdy_o(pop_rdy_o),
    .pop_key_o(pop_key_o), .pop_data_o(pop_data_o), .pop_id_o(pop_id_o),
    .drop_i(drop_i), .drop_id_i(drop_id_i), .drop_rdy_o(drop_rdy_o),
    .drop_hit_o(drop_hit_o), .ch_nonempty_o(ch_nonempty_o), .cnt_o(cnt_o),
    .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .ovf_key_o(ovf_key_o),
    .ovf_data_o(ovf_data_o), .ovf_id_o(ovf_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: an unordered set; priority comes from key, then arrival order.
  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  key;
    logic [15:0] data;
    logic [1:0]  id;
    int          seq;
  } ent_t;

  typedef struct {
    bit          push_rdy;
    logic [1:0]  push_id;
    bit          pop_rdy;
    bit          pop_v;
    logic [7:0]  pk;
    logic [15:0] pd;
    logic [1:0]  pid;
    bit          drop_hit;
    logic [3:0]  ne;
    logic [2:0]  cnt;
    bit          full;
    bit          empty;
    bit          ovf;
    logic [7:0]  ok;
    logic [15:0] od;
    logic [1:0]  oid;
  } exp_t;

  ent_t        m[$];
  exp_t        exp_q[$];
  int          seqc = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_ok = '0;
  logic [15:0] m_od = '0;
  logic [1:0]  m_oid = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit better(input logic [7:0] a, input logic [7:0] b);
    return (MIN_FIRST != 0) ? (a < b) : (a > b);
  endfunction

  function automatic int best_in(input logic [1:0] ch);
    int idx = -1;
    for (int i = 0; i < m.size(); i++)
      if (m[i].ch == ch && (idx < 0 || better(m[i].key, m[idx].key) ||
          (m[i].key == m[idx].key && m[i].seq < m[idx].seq)))
        idx = i;
    return idx;
  endfunction

  function automatic int worst_idx();
    int idx = -1;
    for (int i = 0; i < m.size(); i++)
      if (idx < 0 || better(m[idx].key, m[i].key) ||
          (m[i].key == m[idx].key && m[i].seq > m[idx].seq))
        idx = i;
    return idx;
  endfunction

  function automatic int find_id(input logic [1:0] id);
    for (int i = 0; i < m.size(); i++)
      if (m[i].id == id) return i;
    return -1;
  endfunction

  function automatic logic [1:0] lowest_free();
    for (int i = 0; i < DEPTH; i++)
      if (find_id(2'(i)) < 0) return 2'(i);
    return 2'd0;
  endfunction

  task automatic compute(output exp_t e);
    int  b;
    int  w;
    bit  full;
    full = (m.size() == DEPTH);
    w = worst_idx();
    e.drop_hit = (find_id(drop_id_i) >= 0);
    e.push_rdy = !drop_i && !pop_i &&
                 (!full || ((EVICT != 0) && w >= 0 && better(push_key_i, m[w].key)));
    e.push_id  = (full && (EVICT != 0)) ? m[w].id : lowest_free();
    b = best_in(pop_ch_i);
    e.pop_v    = (b >= 0);
    e.pop_rdy  = !drop_i && e.pop_v;
    e.pk = e.pop_v ? m[b].key  : '0;
    e.pd = e.pop_v ? m[b].data : '0;
    e.pid = e.pop_v ? m[b].id  : '0;
    for (int c = 0; c < NUM_CH; c++) e.ne[c] = (best_in(2'(c)) >= 0);
    e.cnt   = 3'(m.size());
    e.full  = full;
    e.empty = (m.size() == 0);
    e.ovf = m_ovf;
    e.ok  = m_ok;
    e.od  = m_od;
    e.oid = m_oid;
  endtask

  task automatic commit(input exp_t e);
    int i;
    m_ovf = 0;
    if (drop_i) begin
      i = find_id(drop_id_i);
      if (i >= 0) m.delete(i);
    end else if (pop_i && e.pop_rdy) begin
      m.delete(best_in(pop_ch_i));
    end else if (push_i && e.push_rdy) begin
      if (m.size() == DEPTH) begin
        i = worst_idx();
        m_ovf = 1;
        m_ok  = m[i].key;
        m_od  = m[i].data;
        m_oid = m[i].id;
        m.delete(i);
      end
      m.push_back('{ch: push_ch_i, key: push_key_i, data: push_data_i,
                    id: e.push_id, seq: seqc});
      seqc++;
    end
  endtask

  task automatic step(input bit p, input logic [1:0] pc, input logic [7:0] k,
                      input logic [15:0] d, input bit po, input logic [1:0] poc,
                      input bit dr, input logic [1:0] did, input bit rmid);
    exp_t e;
    @(negedge clk_i);
    push_i = p; push_ch_i = pc; push_key_i = k; push_data_i = d;
    pop_i = po; pop_ch_i = poc; drop_i = dr; drop_id_i = did;
    if (rmid) begin
      rst_i = 1'b1;
      m.delete();
      m_ovf = 0; m_ok = '0; m_od = '0; m_oid = '0;
    end
    #1;
    compute(e);
    exp_q.push_back(e);
    if (rmid) begin
      @(posedge clk_i);
      #1 rst_i = 1'b0;
    end else begin
      commit(e);
    end
  endtask

  task automatic do_push(input logic [1:0] ch, input logic [7:0] k, input logic [15:0] d);
    step(1, ch, k, d, 0, ch, 0, 2'd0, 0);
  endtask

  task automatic do_pop(input logic [1:0] ch);
    step(0, 2'd0, 8'd0, 16'd0, 1, ch, 0, 2'd0, 0);
  endtask

  task automatic do_drop(input logic [1:0] id);
    step(0, 2'd0, 8'd0, 16'd0, 0, 2'd0, 1, id, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every settled cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("push_rdy", 32'(push_rdy_o), 32'(e.push_rdy));
        chk("push_id", 32'(push_id_o), 32'(e.push_id));
        chk("pop_rdy", 32'(pop_rdy_o), 32'(e.pop_rdy));
        if (e.pop_v) begin
          chk("pop_key", 32'(pop_key_o), 32'(e.pk));
          chk("pop_data", 32'(pop_data_o), 32'(e.pd));
          chk("pop_id", 32'(pop_id_o), 32'(e.pid));
        end
        chk("drop_rdy", 32'(drop_rdy_o), 32'd1);
        chk("drop_hit", 32'(drop_hit_o), 32'(e.drop_hit));
        chk("ch_nonempty", 32'(ch_nonempty_o), 32'(e.ne));
        chk("cnt", 32'(cnt_o), 32'(e.cnt));
        chk("full", 32'(full_o), 32'(e.full));
        chk("empty", 32'(empty_o), 32'(e.empty));
        chk("ovf", 32'(ovf_o), 32'(e.ovf));
        chk("ovf_key", 32'(ovf_key_o), 32'(e.ok));
        chk("ovf_data", 32'(ovf_data_o), 32'(e.od));
        chk("ovf_id", 32'(ovf_id_o), 32'(e.oid));
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    push_i = 0; pop_i = 0; drop_i = 0;
    push_ch_i = '0; pop_ch_i = '0; drop_id_i = '0;
    push_key_i = '0; push_data_i = '0;

    // Reset state, with a push request that must be discarded.
    step(1, 2'd0, 8'h33, 16'h1111, 0, 2'd0, 0, 2'd0, 1);

    // Ordering and stability of equal keys.
    do_push(2'd0, 8'hF0, 16'h0001);
    do_push(2'd0, 8'h15, 16'h0002);
    do_push(2'd0, 8'h87, 16'h0003);
    do_push(2'd0, 8'h15, 16'hBEEF);
    repeat (4) do_pop(2'd0);
    do_pop(2'd0);

    // Channel isolation.
    do_push(2'd1, 8'h01, 16'h0A01);
    do_push(2'd2, 8'h00, 16'h0A02);
    do_pop(2'd1);
    step(0, 2'd0, 8'd0, 16'd0, 0, 2'd2, 0, 2'd0, 0);
    do_pop(2'd2);

    // Drop by ID, present then absent.
    do_push(2'd0, 8'h01, 16'h0B01);
    do_push(2'd0, 8'hEB, 16'h0B02);
    do_push(2'd0, 8'hAF, 16'h0B03);
    do_drop(2'd2);
    do_drop(2'd2);
    do_pop(2'd0);
    do_pop(2'd0);

    // Eviction when full.
    do_push(2'd0, 8'h10, 16'h0C01);
    do_push(2'd1, 8'h20, 16'h0C02);
    do_push(2'd2, 8'h30, 16'h0C03);
    do_push(2'd3, 8'h40, 16'h0C04);
    do_push(2'd3, 8'h05, 16'h0C05);
    do_push(2'd0, 8'h50, 16'h0C06);
    do_push(2'd0, 8'h10, 16'h0C07);

    // Arbitration: drop beats pop beats push.
    step(1, 2'd0, 8'h01, 16'h0D01, 1, 2'd1, 1, 2'd0, 0);
    step(1, 2'd0, 8'h01, 16'h0D02, 1, 2'd1, 0, 2'd0, 0);
    step(0, 2'd0, 8'd0, 16'd0, 0, 2'd0, 0, 2'd0, 0);

    // Asynchronous reset mid-cycle, then first push after release.
    step(1, 2'd1, 8'h22, 16'h0E01, 0, 2'd0, 0, 2'd0, 1);
    do_push(2'd1, 8'h22, 16'h0E02);

    // Randomised traffic with a narrow key range to provoke ties and eviction.
    for (int n = 0; n < 600; n++) begin
      bit          p, po, dr;
      logic [7:0]  k;
      p  = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 30);
      dr = ($urandom_range(0, 99) < 15);
      k  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      step(p, 2'($urandom_range(0, 3)), k, 16'($urandom_range(0, 65535)),
           po, 2'($urandom_range(0, 3)), dr, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 299) == 0));
    end

    @(negedge clk_i);
    #5;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
